gpio_port: RTL and testbench

//   Memory-mapped GPIO output peripheral between the riscv core's data bus and the

---
 rtl/gpio_port.sv | 194 +++++++++++++++++++
 tb/tb_gpio_port.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_port.sv
// -----------------------------------------------------------------------------
// gpio_port
//   Memory-mapped GPIO output peripheral sitting between the core data bus and
//   the board LED/GPIO pins. Holds the pin output register (OUT), offers atomic
//   SET/CLR/TOGGLE aliases, and runs a blink engine that toggles the pins
//   selected by BLINK every PRESC+1 cycles without any CPU involvement.
//
// Ports
//   clk        in   1         system clock
//   rst_n      in   1         asynchronous reset, active-low
//   bus_valid  in   1         request strobe, held high until bus_ready
//   bus_we     in   1         1 = write, 0 = read
//   bus_addr   in   3         register word index
//   bus_wdata  in   32        write data
//   bus_ready  out  1         one-cycle acknowledge
//   bus_rdata  out  32        read data, valid only while bus_ready = 1
//   gpio       out  NUM_BITS  pin outputs, driven directly from OUT
//
// Register map (bus_addr)
//   0 OUT     rw   OUT = wdata
//   1 SET     w    OUT |= wdata     (reads return OUT)
//   2 CLR     w    OUT &= ~wdata    (reads return OUT)
//   3 TOGGLE  w    OUT ^= wdata     (reads return OUT)
//   4 BLINK   rw   mask of pins toggled on every prescaler tick
//   5 PRESC   rw   tick period - 1; a write also clears the counter
//   6,7       reserved: writes ignored, reads 0, still acknowledged
//
// Bus handshake
//   A request is taken when bus_valid is seen high in IDLE. The access is
//   performed at that edge and the FSM moves to ACK, where bus_ready is high
//   for exactly one cycle and bus_rdata carries the read data (zero
//   otherwise). bus_valid is ignored in ACK, so a master that keeps valid
//   high until it sees ready never has its access executed twice.
// -----------------------------------------------------------------------------
module gpio_port #(
  parameter int                  NUM_BITS      = 8,
  parameter int                  PRESC_W       = 24,
  parameter logic [PRESC_W-1:0]  PRESC_DEFAULT = 24'd5999
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bus_valid,
  input  logic                bus_we,
  input  logic [2:0]          bus_addr,
  input  logic [31:0]         bus_wdata,
  output logic                bus_ready,
  output logic [31:0]         bus_rdata,
  output logic [NUM_BITS-1:0] gpio
);

  localparam logic [2:0] ADDR_OUT    = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLR    = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE = 3'd3;
  localparam logic [2:0] ADDR_BLINK  = 3'd4;
  localparam logic [2:0] ADDR_PRESC  = 3'd5;

  localparam logic [PRESC_W-1:0] CNT_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  bus_state_t          state_q, state_nx;
  logic [NUM_BITS-1:0] out_q, out_nx;
  logic [NUM_BITS-1:0] blink_q, blink_nx;
  logic [PRESC_W-1:0]  presc_q, presc_nx;
  logic [PRESC_W-1:0]  cnt_q, cnt_nx;
  logic [31:0]         rdata_q, rdata_nx;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic                access;
  logic                wr_en;
  logic                rd_en;
  logic                presc_wr;
  logic                tick;
  logic [NUM_BITS-1:0] wr_bits;
  logic [PRESC_W-1:0]  wr_presc;
  logic [NUM_BITS-1:0] out_wr;
  logic [31:0]         rd_val;

  // Bits above the widest register field carry no meaning.
  logic unused_wdata;
  assign unused_wdata = ^bus_wdata[31:PRESC_W];

  assign access   = (state_q == ST_IDLE) && bus_valid;
  assign wr_en    = access && bus_we;
  assign rd_en    = access && !bus_we;
  assign wr_bits  = bus_wdata[NUM_BITS-1:0];
  assign wr_presc = bus_wdata[PRESC_W-1:0];

  // ---------------------------------------------------------------------------
  // Bus FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE: if (bus_valid) state_nx = ST_ACK;
      ST_ACK:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register writes (OUT result before the blink toggle is applied)
  // ---------------------------------------------------------------------------
  always_comb begin
    out_wr   = out_q;
    blink_nx = blink_q;
    presc_nx = presc_q;
    presc_wr = 1'b0;
    if (wr_en) begin
      case (bus_addr)
        ADDR_OUT:    out_wr   = wr_bits;
        ADDR_SET:    out_wr   = out_q | wr_bits;
        ADDR_CLR:    out_wr   = out_q & ~wr_bits;
        ADDR_TOGGLE: out_wr   = out_q ^ wr_bits;
        ADDR_BLINK:  blink_nx = wr_bits;
        ADDR_PRESC: begin
          presc_nx = wr_presc;
          presc_wr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler and blink
  //   cnt runs 0..PRESC and the tick fires on the terminal count. A PRESC
  //   write restarts the period from zero and swallows any tick on that edge,
  //   so the next tick lands exactly PRESC+1 edges after the write.
  //   The toggle uses the BLINK value held before this edge, so a BLINK write
  //   coinciding with a tick only takes effect from the following tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    tick   = (cnt_q == presc_q) && !presc_wr;
    cnt_nx = cnt_q + CNT_ONE;
    if (presc_wr || (cnt_q == presc_q)) begin
      cnt_nx = '0;
    end
    out_nx = out_wr ^ (tick ? blink_q : '0);
  end

  // ---------------------------------------------------------------------------
  // Read mux; data is captured only for a read taken this edge, so bus_rdata
  // is zero in every cycle where bus_ready is low.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_val = '0;
    case (bus_addr)
      ADDR_OUT, ADDR_SET, ADDR_CLR, ADDR_TOGGLE: rd_val[NUM_BITS-1:0] = out_q;
      ADDR_BLINK:                                rd_val[NUM_BITS-1:0] = blink_q;
      ADDR_PRESC:                                rd_val[PRESC_W-1:0]  = presc_q;
      default:                                   rd_val = '0;
    endcase
    rdata_nx = rd_en ? rd_val : '0;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      blink_q <= '0;
      presc_q <= PRESC_DEFAULT;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_nx;
      out_q   <= out_nx;
      blink_q <= blink_nx;
      presc_q <= presc_nx;
      cnt_q   <= cnt_nx;
      rdata_q <= rdata_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all straight from flops.
  // ---------------------------------------------------------------------------
  assign bus_ready = (state_q == ST_ACK);
  assign bus_rdata = rdata_q;
  assign gpio      = out_q;

endmodule

// File: tb/tb_gpio_port.sv
module tb_gpio_port;

  logic        clk;
  logic        rst_n;
  logic        bus_valid;
  logic        bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic [7:0]  gpio;

  int total = 0;
  int bad   = 0;

  gpio_port #(
    .NUM_BITS      (8),
    .PRESC_W       (24),
    .PRESC_DEFAULT (24'd5999)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_valid (bus_valid),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata),
    .gpio      (gpio)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "simulation timeout");
  end

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp_v);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one complete access. Inputs change on the falling edge; outputs
  // are sampled 1 time unit after the rising edge. Returns read data and the
  // pin value seen right after the acknowledge edge.
  // ---------------------------------------------------------------------------
  task automatic bus_xfer(input string tag, input logic we, input logic [2:0] addr,
                          input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic [7:0] gpio_ack);
    int n;
    @(negedge clk);
    bus_valid = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus_ready && n < 8);
    chk({tag, "_ready_lat"}, n, 1);
    rdata    = bus_rdata;
    gpio_ack = gpio;
    @(negedge clk);
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_wdata = '0;
    @(posedge clk);
    #1;
    chk({tag, "_ready_drop"}, {31'd0, bus_ready}, 0);
    chk({tag, "_rdata_idle"}, bus_rdata, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] rd;
    logic [7:0]  ga;
    logic [7:0]  g0;
    int          last;
    int          ntog;
    int          bad_int;
    int          hi_bad;
    int          n;

    rst_n     = 1'b0;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpio",  {24'd0, gpio}, 0);
    chk("rst_ready", {31'd0, bus_ready}, 0);
    chk("rst_rdata", bus_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_gpio", {24'd0, gpio}, 0);

    // Reset values through the bus
    bus_xfer("rd_presc_dflt", 1'b0, 3'd5, 32'd0, rd, ga);
    chk("presc_default", rd, 32'h0000_176F);
    bus_xfer("rd_blink_dflt", 1'b0, 3'd4, 32'd0, rd, ga);
    chk("blink_default", rd, 32'h0);

    // OUT write and readback
    bus_xfer("wr_out", 1'b1, 3'd0, 32'h0000_00A5, rd, ga);
    chk("out_a5_at_ack", {24'd0, ga}, 32'hA5);
    bus_xfer("rd_out", 1'b0, 3'd0, 32'd0, rd, ga);
    chk("rd_out_a5", rd, 32'h0000_00A5);

    // Atomic aliases
    bus_xfer("wr_set", 1'b1, 3'd1, 32'h0000_000F, rd, ga);
    chk("set_0f", {24'd0, ga}, 32'hAF);
    bus_xfer("wr_clr", 1'b1, 3'd2, 32'h0000_0081, rd, ga);
    chk("clr_81", {24'd0, ga}, 32'h2E);
    bus_xfer("wr_tog", 1'b1, 3'd3, 32'h0000_00FF, rd, ga);
    chk("tog_ff", {24'd0, ga}, 32'hD1);
    bus_xfer("rd_set_alias", 1'b0, 3'd1, 32'd0, rd, ga);
    chk("rd_set_alias", rd, 32'hD1);
    bus_xfer("rd_tog_alias", 1'b0, 3'd3, 32'd0, rd, ga);
    chk("rd_tog_alias", rd, 32'hD1);

    // Valid held through the ACK cycle: TOGGLE must execute once only
    @(negedge clk);
    bus_valid = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = 3'd3;
    bus_wdata = 32'h0000_0001;
    @(posedge clk);
    #1;
    chk("hold_ready_1", {31'd0, bus_ready}, 1);
    chk("hold_gpio_1", {24'd0, gpio}, 32'hD0);
    @(posedge clk);
    #1;
    chk("hold_ready_2", {31'd0, bus_ready}, 0);
    chk("hold_gpio_2", {24'd0, gpio}, 32'hD0);
    @(negedge clk);
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_gpio_3", {24'd0, gpio}, 32'hD0);

    // Upper write bits ignored, reserved address behaviour
    bus_xfer("wr_out_wide", 1'b1, 3'd0, 32'hFFFF_FF3C, rd, ga);
    chk("out_wide", {24'd0, ga}, 32'h3C);
    bus_xfer("wr_rsvd7", 1'b1, 3'd7, 32'h0000_00FF, rd, ga);
    chk("rsvd7_no_effect", {24'd0, ga}, 32'h3C);
    bus_xfer("rd_rsvd6", 1'b0, 3'd6, 32'd0, rd, ga);
    chk("rd_rsvd6", rd, 32'h0);
    bus_xfer("rd_out_wide", 1'b0, 3'd0, 32'd0, rd, ga);
    chk("rd_out_wide", rd, 32'h0000_003C);

    // Blink engine: PRESC=3 -> period 4 cycles, only bit 0 moves
    bus_xfer("wr_out0", 1'b1, 3'd0, 32'h0, rd, ga);
    bus_xfer("wr_presc3", 1'b1, 3'd5, 32'h3, rd, ga);
    bus_xfer("rd_presc3", 1'b0, 3'd5, 32'd0, rd, ga);
    chk("rd_presc3", rd, 32'h3);
    bus_xfer("wr_blink1", 1'b1, 3'd4, 32'h1, rd, ga);
    last    = -1;
    ntog    = 0;
    bad_int = 0;
    hi_bad  = 0;
    g0      = gpio;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (gpio[7:1] !== 7'd0) hi_bad++;
      if (gpio !== g0) begin
        if (last >= 0 && (c - last) != 4) bad_int++;
        last = c;
        ntog++;
        g0 = gpio;
      end
    end
    chk("blink_enough_toggles", {31'd0, (ntog >= 4)}, 1);
    chk("blink_interval", bad_int, 0);
    chk("blink_high_bits", hi_bad, 0);

    // PRESC rewrite restarts the period: next toggle 4 edges after the write
    bus_xfer("wr_presc3_again", 1'b1, 3'd5, 32'h3, rd, ga);
    g0 = ga;
    chk("presc_rewrite_no_tick", {24'd0, gpio}, {24'd0, g0});
    n = 1;
    while (n < 8) begin
      @(posedge clk);
      #1;
      n++;
      if (gpio !== g0) break;
    end
    chk("presc_rewrite_delay", n, 4);

    // PRESC=0: tick every edge; OUT write collides with tick
    bus_xfer("wr_presc0", 1'b1, 3'd5, 32'h0, rd, ga);
    bus_xfer("wr_out_collide", 1'b1, 3'd0, 32'h0, rd, ga);
    chk("collide_at_ack", {24'd0, ga}, 32'h01);
    chk("collide_next", {24'd0, gpio}, 32'h00);
    bus_xfer("wr_blink0", 1'b1, 3'd4, 32'h0, rd, ga);
    bus_xfer("wr_out_after", 1'b1, 3'd0, 32'h0000_0042, rd, ga);
    repeat (3) @(posedge clk);
    #1;
    chk("blink_stopped", {24'd0, gpio}, 32'h42);

    // Reset asserted during ACK
    bus_xfer("wr_blink0f", 1'b1, 3'd4, 32'h0F, rd, ga);
    bus_xfer("wr_presc10", 1'b1, 3'd5, 32'h10, rd, ga);
    @(negedge clk);
    bus_valid = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = 3'd0;
    bus_wdata = 32'h0000_00AA;
    @(posedge clk);
    #1;
    chk("pre_rst_ready", {31'd0, bus_ready}, 1);
    chk("pre_rst_gpio", {24'd0, gpio}, 32'hAA);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", {31'd0, bus_ready}, 0);
    chk("async_rst_gpio", {24'd0, gpio}, 32'h0);
    chk("async_rst_presc", {8'd0, dut.presc_q}, 32'h0000_176F);
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("no_ack_after_abort", {31'd0, bus_ready}, 0);
    end
    bus_xfer("rd_blink_rst", 1'b0, 3'd4, 32'd0, rd, ga);
    chk("blink_after_rst", rd, 32'h0);
    bus_xfer("rd_presc_rst", 1'b0, 3'd5, 32'd0, rd, ga);
    chk("presc_after_rst", rd, 32'h0000_176F);
    bus_xfer("rd_out_rst", 1'b0, 3'd0, 32'd0, rd, ga);
    chk("out_after_rst", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
